// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command bridge: FSM states, response
// bytes, command byte layout and the byte-count helper.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    RD_WAIT,
    RD_CAP,
    TX
  } state_e;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  localparam int unsigned WR_BIT  = 7;
  localparam int unsigned RSV_MSB = 6;
  localparam int unsigned RSV_LSB = 4;
  localparam int unsigned TGT_MSB = 3;

  // Command byte as received on the link
  typedef struct packed {
    logic                     wr;
    logic [RSV_MSB-RSV_LSB:0] rsv;
    logic [TGT_MSB:0]         tgt;
  } cmd_t;

  // Number of link bytes needed to carry a w-bit field
  function automatic int unsigned byte_cnt(input int unsigned w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Response serializer: loads up to NB bytes in parallel and emits them
// MSB first over the tx_valid/tx_ready handshake.
// Ports: clk, reset (async, active-high); load/load_data/load_cnt parallel
// load (bytes left-aligned in load_data); tx_data/tx_valid/tx_ready byte
// handshake; done_c pulses on the handshake of the final byte.
module uart_tx_shifter #(
  parameter int unsigned NB    = 4,
  parameter int unsigned CNT_W = $clog2(NB + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [NB*8-1:0]   load_data,
  input  logic [CNT_W-1:0]  load_cnt,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done_c
);

  logic [NB*8-1:0]  sr;
  logic [CNT_W-1:0] cnt;

  // Head byte of the shift register is the byte on the link
  assign tx_data = sr[NB*8-1 -: 8];
  assign done_c  = tx_valid && tx_ready && (cnt == CNT_W'(1));

  // Shift one byte out per accepted handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      sr       <= load_data;
      cnt      <= load_cnt;
      tx_valid <= (load_cnt != '0);
    end else if (tx_valid && tx_ready) begin
      sr  <= sr << 8;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// Byte-level command bridge between a UART byte PHY and NUM_TGT
// word-addressed memories. Parses write/read frames, drives the shared
// address/data bus and one-hot write strobes, returns ACK/NAK or read data,
// and raises hold while a command is in flight.
// Ports: clk, reset (async, active-high); rx_data/rx_valid received bytes;
// tx_data/tx_valid/tx_ready response bytes; mem_addr/mem_wdata/mem_we target
// bus; mem_rdata packed per-target read data (1-cycle latency); hold.
// Optional: define RX_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYC
// idle cycles with a NAK.
module uart_cmd_bridge
  import uart_cmd_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_TGT     = 2,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [NUM_TGT-1:0]        mem_we,
  input  logic [NUM_TGT*DATA_W-1:0] mem_rdata,
  output logic                      hold
);

  localparam int unsigned AB    = byte_cnt(ADDR_W);
  localparam int unsigned DB    = byte_cnt(DATA_W);
  localparam int unsigned MAXB  = (AB > DB) ? AB : DB;
  localparam int unsigned BC_W  = $clog2(MAXB + 1);
  localparam int unsigned TXC_W = $clog2(DB + 1);
  localparam int unsigned TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  if ((DATA_W % 8 != 0) || (DATA_W < 8) || (DATA_W > 64) || (ADDR_W < 1) ||
      (NUM_TGT < 1) || (NUM_TGT > 16) || (TIMEOUT_CYC < 1)) begin : g_bad_param
    $error("uart_cmd_bridge: illegal parameter set");
  end

  state_e              state, state_nxt;
  logic [TGT_W-1:0]    tgt, tgt_nxt;
  logic                is_wr, wr_nxt;
  logic [BC_W-1:0]     bcnt, bcnt_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic [NUM_TGT-1:0]  we_nxt;
  logic                hold_nxt;

  cmd_t                cmd_c;
  logic                cmd_ok_c;
  logic [DATA_W-1:0]   rsel_c;
  logic                ld_c;
  logic [DATA_W-1:0]   ld_data_c;
  logic [TXC_W-1:0]    ld_cnt_c;
  logic                tx_done_c;

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
`endif

  assign cmd_c    = cmd_t'(rx_data);
  assign cmd_ok_c = (cmd_c.rsv == '0) && (32'(cmd_c.tgt) < NUM_TGT);

  // Read-data slice of the latched target
  always_comb begin
    rsel_c = '0;
    for (int unsigned t = 0; t < NUM_TGT; t++) begin
      if (tgt == TGT_W'(t)) rsel_c = mem_rdata[t*DATA_W +: DATA_W];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    wr_nxt    = is_wr;
    bcnt_nxt  = bcnt;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    we_nxt    = '0;
    hold_nxt  = hold;
    ld_c      = 1'b0;
    ld_data_c = '0;
    ld_cnt_c  = '0;
`ifdef RX_TIMEOUT_EN
    tmo_nxt   = '0;
`endif

    case (state)
      IDLE: begin
        if (rx_valid) begin
          hold_nxt = 1'b1;
          bcnt_nxt = '0;
          if (cmd_ok_c) begin
            tgt_nxt   = TGT_W'(cmd_c.tgt);
            wr_nxt    = cmd_c.wr;
            state_nxt = ADDR;
          end else begin
            ld_c      = 1'b1;
            ld_data_c = DATA_W'(NAK_BYTE) << (DATA_W - 8);
            ld_cnt_c  = TXC_W'(1);
            state_nxt = TX;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          // Upper bits beyond ADDR_W fall off the top of the shift
          addr_nxt = ADDR_W'({mem_addr, rx_data});
          if (bcnt == BC_W'(AB - 1)) begin
            bcnt_nxt  = '0;
            state_nxt = is_wr ? DATA : RD_WAIT;
          end else begin
            bcnt_nxt = bcnt + BC_W'(1);
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          wdata_nxt = DATA_W'({mem_wdata, rx_data});
          if (bcnt == BC_W'(DB - 1)) begin
            bcnt_nxt  = '0;
            state_nxt = WRITE;
            for (int unsigned t = 0; t < NUM_TGT; t++) begin
              we_nxt[t] = (tgt == TGT_W'(t));
            end
          end else begin
            bcnt_nxt = bcnt + BC_W'(1);
          end
        end
      end
      WRITE: begin
        ld_c      = 1'b1;
        ld_data_c = DATA_W'(ACK_BYTE) << (DATA_W - 8);
        ld_cnt_c  = TXC_W'(1);
        state_nxt = TX;
      end
      RD_WAIT: state_nxt = RD_CAP;
      RD_CAP: begin
        ld_c      = 1'b1;
        ld_data_c = rsel_c;
        ld_cnt_c  = TXC_W'(DB);
        state_nxt = TX;
      end
      TX: begin
        if (tx_done_c) begin
          state_nxt = IDLE;
          hold_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = 1'b0;
      end
    endcase

`ifdef RX_TIMEOUT_EN
    // Abort a stalled partial frame with a NAK
    if ((state == ADDR || state == DATA) && !rx_valid) begin
      if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
        bcnt_nxt  = '0;
        ld_c      = 1'b1;
        ld_data_c = DATA_W'(NAK_BYTE) << (DATA_W - 8);
        ld_cnt_c  = TXC_W'(1);
        state_nxt = TX;
      end else begin
        tmo_nxt = tmo_cnt + TMO_W'(1);
      end
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tgt       <= '0;
      is_wr     <= 1'b0;
      bcnt      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= '0;
      hold      <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      is_wr     <= wr_nxt;
      bcnt      <= bcnt_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_we    <= we_nxt;
      hold      <= hold_nxt;
`ifdef RX_TIMEOUT_EN
      tmo_cnt   <= tmo_nxt;
`endif
    end
  end

  uart_tx_shifter #(
    .NB    (DB),
    .CNT_W (TXC_W)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (ld_c),
    .load_data (ld_data_c),
    .load_cnt  (ld_cnt_c),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done_c    (tx_done_c)
  );

endmodule
